// File: rtl/zeroheti_obi_rr_arbiter.sv
// N-to-1 OBI arbiter: round-robin grant with request locking, plus a grant-ID
// FIFO that steers in-order subordinate responses back to the issuing manager.
module zeroheti_obi_rr_arbiter #(
  parameter int NumMgr    = 3,
  parameter int MaxTrans  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumMgr-1:0]               mgr_req_i,
  output logic [NumMgr-1:0]               mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]     mgr_addr_i,
  input  logic [NumMgr-1:0]               mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0]   mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]     mgr_wdata_i,
  output logic [NumMgr-1:0]               mgr_rvalid_o,
  output logic [DataWidth-1:0]            mgr_rdata_o,
  output logic                            mgr_err_o,
  output logic                            sbr_req_o,
  input  logic                            sbr_gnt_i,
  output logic [AddrWidth-1:0]            sbr_addr_o,
  output logic                            sbr_we_o,
  output logic [DataWidth/8-1:0]          sbr_be_o,
  output logic [DataWidth-1:0]            sbr_wdata_o,
  input  logic                            sbr_rvalid_i,
  input  logic [DataWidth-1:0]            sbr_rdata_i,
  input  logic                            sbr_err_i,
  output logic [$clog2(MaxTrans+1)-1:0]   outstanding_o,
  output logic                            resp_orphan_o
);

  localparam int IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW = $clog2(MaxTrans + 1);
  localparam int BeW  = DataWidth / 8;
  localparam logic [IdxW-1:0] LastMgr = IdxW'(NumMgr - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxTrans);

  logic [IdxW-1:0] rr_ptr_q;
  logic            lock_q;
  logic [IdxW-1:0] locked_idx_q;
  logic [IdxW-1:0] fifo_q [MaxTrans];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic [IdxW-1:0] rr_sel;
  logic [IdxW-1:0] cand;
  logic            found;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            grant;
  logic            pop;

  // Round-robin search starting at rr_ptr; falls back to rr_ptr when idle.
  always_comb begin
    rr_sel = rr_ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < NumMgr; k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % NumMgr);
      if (!found && mgr_req_i[cand]) begin
        rr_sel = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel        = lock_q ? locked_idx_q : rr_sel;
  assign fifo_full  = (cnt_q == FullCnt);
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Outputs are gated by reset so the port reads idle while rst_ni is low.
  assign sbr_req_o = rst_ni & mgr_req_i[sel] & ~fifo_full;
  assign grant     = sbr_req_o & sbr_gnt_i;
  assign pop       = rst_ni & sbr_rvalid_i & ~fifo_empty;

  assign sbr_addr_o  = mgr_addr_i[int'(sel)*AddrWidth +: AddrWidth];
  assign sbr_we_o    = mgr_we_i[sel];
  assign sbr_be_o    = mgr_be_i[int'(sel)*BeW +: BeW];
  assign sbr_wdata_o = mgr_wdata_i[int'(sel)*DataWidth +: DataWidth];

  always_comb begin
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    if (grant) mgr_gnt_o[sel] = 1'b1;
    for (int i = 0; i < NumMgr; i++) begin
      if (pop && head == IdxW'(i)) mgr_rvalid_o[i] = 1'b1;
    end
  end

  assign mgr_rdata_o   = sbr_rdata_i;
  assign mgr_err_o     = sbr_err_i;
  assign resp_orphan_o = rst_ni & sbr_rvalid_i & fifo_empty;
  assign outstanding_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < MaxTrans; i++) fifo_q[i] <= '0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        rr_ptr_q         <= (sel == LastMgr) ? '0 : sel + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (grant && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!grant && pop) cnt_q <= cnt_q - 1'b1;

      // A pending ungranted request pins the selection; when not full and no
      // request is presented, a locked manager has withdrawn, so unlock.
      if (grant) begin
        lock_q <= 1'b0;
      end else if (sbr_req_o) begin
        lock_q       <= 1'b1;
        locked_idx_q <= sel;
      end else if (!fifo_full) begin
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zeroheti_obi_rr_arbiter.sv
// Directed, table-driven bench for zeroheti_obi_rr_arbiter (3 managers, depth 2).
module tb_zeroheti_obi_rr_arbiter;

  localparam int N  = 3;
  localparam int MT = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk_i;
  logic              rst_ni;
  logic [N-1:0]      mgr_req_i;
  logic [N-1:0]      mgr_gnt_o;
  logic [N*AW-1:0]   mgr_addr_i;
  logic [N-1:0]      mgr_we_i;
  logic [N*DW/8-1:0] mgr_be_i;
  logic [N*DW-1:0]   mgr_wdata_i;
  logic [N-1:0]      mgr_rvalid_o;
  logic [DW-1:0]     mgr_rdata_o;
  logic              mgr_err_o;
  logic              sbr_req_o;
  logic              sbr_gnt_i;
  logic [AW-1:0]     sbr_addr_o;
  logic              sbr_we_o;
  logic [DW/8-1:0]   sbr_be_o;
  logic [DW-1:0]     sbr_wdata_o;
  logic              sbr_rvalid_i;
  logic [DW-1:0]     sbr_rdata_i;
  logic              sbr_err_i;
  logic [1:0]        outstanding_o;
  logic              resp_orphan_o;

  zeroheti_obi_rr_arbiter #(
    .NumMgr(N), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
    .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o),
    .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i),
    .outstanding_o(outstanding_o), .resp_orphan_o(resp_orphan_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] req;
    logic       gnt;
    logic       rv;
    logic       e_req;
    logic [2:0] e_gnt;
    logic [2:0] e_rv;
    logic       e_orph;
    logic [1:0] e_out;
    int         e_sel;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h10;
  endfunction
  function automatic logic [31:0] wdata_of(input int i);
    return 32'h5000_0000 + 32'(i);
  endfunction
  function automatic logic [3:0] be_of(input int i);
    return 4'b0001 << i;
  endfunction
  function automatic logic we_of(input int i);
    return (i != 1);
  endfunction

  task automatic add(input logic [2:0] req, input logic gnt, input logic rv,
                     input logic e_req, input logic [2:0] e_gnt, input logic [2:0] e_rv,
                     input logic e_orph, input logic [1:0] e_out, input int e_sel);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.e_req = e_req; v.e_gnt = e_gnt;
    v.e_rv = e_rv; v.e_orph = e_orph; v.e_out = e_out; v.e_sel = e_sel;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic gnt, input logic rv);
    mgr_req_i    = req;
    sbr_gnt_i    = gnt;
    sbr_rvalid_i = rv;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < N; i++) begin
      mgr_addr_i[i*AW +: AW]   = addr_of(i);
      mgr_wdata_i[i*DW +: DW]  = wdata_of(i);
      mgr_be_i[i*4 +: 4]       = be_of(i);
      mgr_we_i[i]              = we_of(i);
    end
    sbr_rdata_i = '0;
    sbr_err_i   = 1'b0;

    // Reset state with active inputs: everything must read idle.
    rst_ni = 1'b0;
    drive(3'b111, 1'b1, 1'b1);
    #3;
    check("rst_req", 32'(sbr_req_o), 32'd0);
    check("rst_gnt", 32'(mgr_gnt_o), 32'd0);
    check("rst_rvalid", 32'(mgr_rvalid_o), 32'd0);
    check("rst_orphan", 32'(resp_orphan_o), 32'd0);
    check("rst_out", 32'(outstanding_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    @(posedge clk_i); #1;

    // req   gnt  rv  | e_req e_gnt   e_rv    orph out sel
    add(3'b010, 1, 0, 1, 3'b010, 3'b000, 0, 0, 1);  // single manager
    add(3'b000, 0, 1, 0, 3'b000, 3'b010, 0, 1, 0);
    add(3'b010, 1, 0, 1, 3'b010, 3'b000, 0, 0, 1);
    add(3'b000, 0, 1, 0, 3'b000, 3'b010, 0, 1, 0);
    add(3'b000, 0, 1, 0, 3'b000, 3'b000, 1, 0, 0);  // orphan response
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    add(3'b111, 1, 0, 1, 3'b100, 3'b000, 0, 0, 2);  // fairness, rr_ptr=2
    add(3'b111, 1, 1, 1, 3'b001, 3'b100, 0, 1, 0);
    add(3'b111, 1, 1, 1, 3'b010, 3'b001, 0, 1, 1);
    add(3'b111, 1, 1, 1, 3'b100, 3'b010, 0, 1, 2);
    add(3'b111, 1, 1, 1, 3'b001, 3'b100, 0, 1, 0);
    add(3'b111, 1, 1, 1, 3'b010, 3'b001, 0, 1, 1);
    add(3'b000, 0, 1, 0, 3'b000, 3'b010, 0, 1, 0);
    add(3'b100, 1, 0, 1, 3'b100, 3'b000, 0, 0, 2);  // bring rr_ptr to 0
    add(3'b000, 0, 1, 0, 3'b000, 3'b100, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      add(3'b101, 0, 0, 1, 3'b000, 3'b000, 0, 0, 0);  // lock on manager 0
    add(3'b101, 1, 0, 1, 3'b001, 3'b000, 0, 0, 0);
    add(3'b100, 1, 1, 1, 3'b100, 3'b001, 0, 1, 2);
    add(3'b000, 0, 1, 0, 3'b000, 3'b100, 0, 1, 0);
    add(3'b010, 0, 0, 1, 3'b000, 3'b000, 0, 0, 1);  // lock on 1 beats new req 0
    add(3'b011, 1, 0, 1, 3'b010, 3'b000, 0, 0, 1);
    add(3'b000, 0, 1, 0, 3'b000, 3'b010, 0, 1, 0);
    add(3'b001, 0, 0, 1, 3'b000, 3'b000, 0, 0, 0);  // locked manager drops
    add(3'b100, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    add(3'b100, 1, 0, 1, 3'b100, 3'b000, 0, 0, 2);
    add(3'b000, 0, 1, 0, 3'b000, 3'b100, 0, 1, 0);
    add(3'b011, 1, 0, 1, 3'b001, 3'b000, 0, 0, 0);  // backpressure
    add(3'b011, 1, 0, 1, 3'b010, 3'b000, 0, 1, 1);
    add(3'b011, 1, 0, 0, 3'b000, 3'b000, 0, 2, 0);
    add(3'b011, 1, 1, 0, 3'b000, 3'b001, 0, 2, 0);  // pop while full: no issue
    add(3'b011, 1, 0, 1, 3'b001, 3'b000, 0, 1, 0);
    add(3'b000, 0, 1, 0, 3'b000, 3'b010, 0, 2, 0);
    add(3'b000, 0, 1, 0, 3'b000, 3'b001, 0, 1, 0);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].req, vecs[k].gnt, vecs[k].rv);
      rd = $urandom;
      er = 1'($urandom_range(0, 1));
      sbr_rdata_i = rd;
      sbr_err_i   = er;
      #3;
      check($sformatf("v%0d_req", k), 32'(sbr_req_o), 32'(vecs[k].e_req));
      check($sformatf("v%0d_gnt", k), 32'(mgr_gnt_o), 32'(vecs[k].e_gnt));
      check($sformatf("v%0d_rvalid", k), 32'(mgr_rvalid_o), 32'(vecs[k].e_rv));
      check($sformatf("v%0d_orphan", k), 32'(resp_orphan_o), 32'(vecs[k].e_orph));
      check($sformatf("v%0d_out", k), 32'(outstanding_o), 32'(vecs[k].e_out));
      check($sformatf("v%0d_rdata", k), mgr_rdata_o, rd);
      check($sformatf("v%0d_err", k), 32'(mgr_err_o), 32'(er));
      if (vecs[k].e_req) begin
        check($sformatf("v%0d_addr", k), sbr_addr_o, addr_of(vecs[k].e_sel));
        check($sformatf("v%0d_wdata", k), sbr_wdata_o, wdata_of(vecs[k].e_sel));
        check($sformatf("v%0d_be", k), 32'(sbr_be_o), 32'(be_of(vecs[k].e_sel)));
        check($sformatf("v%0d_we", k), 32'(sbr_we_o), 32'(we_of(vecs[k].e_sel)));
      end
      @(posedge clk_i); #1;
    end

    // Reset with two transactions outstanding (rr_ptr is 1 here).
    drive(3'b011, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("pre_rst_out", 32'(outstanding_o), 32'd2);
    sbr_rvalid_i = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_out", 32'(outstanding_o), 32'd0);
    check("mid_rst_req", 32'(sbr_req_o), 32'd0);
    check("mid_rst_gnt", 32'(mgr_gnt_o), 32'd0);
    check("mid_rst_rvalid", 32'(mgr_rvalid_o), 32'd0);
    check("mid_rst_orphan", 32'(resp_orphan_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(3'b111, 1'b1, 1'b0);
    #1;
    check("post_rst_gnt", 32'(mgr_gnt_o), 32'b001);
    @(posedge clk_i); #1;
    drive(3'b000, 1'b0, 1'b1);
    #1;
    check("post_rst_rvalid", 32'(mgr_rvalid_o), 32'b001);
    check("post_rst_out", 32'(outstanding_o), 32'd1);
    check("post_rst_no_orphan", 32'(resp_orphan_o), 32'd0);
    @(posedge clk_i); #1;
    #1;
    check("late_orphan", 32'(resp_orphan_o), 32'd1);
    check("late_rvalid", 32'(mgr_rvalid_o), 32'd0);
    check("late_out", 32'(outstanding_o), 32'd0);
    @(posedge clk_i); #1;
    drive(3'b000, 1'b0, 1'b0);
    @(posedge clk_i); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zeroheti_obi_rr_arbiter.md
Name: zeroheti_obi_rr_arbiter

Overview:
- N-to-1 OBI arbiter. It shares one OBI subordinate (dmem, hetic or the APB bridge port) between several OBI managers: debug SBA, Ibex instruction port and Ibex data port.
- Grants are round-robin with request locking, as OBI requires.
- A grant-ID FIFO tracks outstanding transactions, so each response is routed back to the manager that issued it.
- Sits between the manager ports and a shared subordinate, either inside or beside the core crossbar.

Parameters:
- NumMgr, 3, number of requesting managers (at least 2).
- MaxTrans, 2, maximum outstanding transactions; this is the grant-ID FIFO depth (at least 1).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- mgr_req_i  in  NumMgr  per-manager request
- mgr_gnt_o  out  NumMgr  per-manager grant, one-hot or zero
- mgr_addr_i  in  NumMgr*AddrWidth  packed addresses, manager 0 in the LSBs
- mgr_we_i  in  NumMgr  write enables
- mgr_be_i  in  NumMgr*DataWidth/8  byte enables
- mgr_wdata_i  in  NumMgr*DataWidth  write data
- mgr_rvalid_o  out  NumMgr  per-manager response valid, one-hot or zero
- mgr_rdata_o  out  DataWidth  response data, broadcast to all managers
- mgr_err_o  out  1  response error, broadcast to all managers
- sbr_req_o  out  1  request to the subordinate
- sbr_gnt_i  in  1  grant from the subordinate
- sbr_addr_o  out  AddrWidth  muxed address
- sbr_we_o  out  1  muxed write enable
- sbr_be_o  out  DataWidth/8  muxed byte enables
- sbr_wdata_o  out  DataWidth  muxed write data
- sbr_rvalid_i  in  1  subordinate response valid
- sbr_rdata_i  in  DataWidth  subordinate read data
- sbr_err_i  in  1  subordinate error
- outstanding_o  out  $clog2(MaxTrans+1)  number of in-flight transactions
- resp_orphan_o  out  1  one-cycle pulse: sbr_rvalid_i arrived while no transaction was outstanding

Behaviour:
- Reset values: rr_ptr = 0, lock = 0, FIFO empty, outstanding_o = 0, resp_orphan_o = 0. All mgr_gnt_o, mgr_rvalid_o and sbr_req_o are 0.
- Arbitration:
  - With lock = 0, sel is the first index i with mgr_req_i[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NumMgr.
  - With lock = 1, sel = locked_idx.
- Issue:
  - sbr_req_o = mgr_req_i[sel] AND NOT fifo_full.
  - sbr_addr_o, sbr_we_o, sbr_be_o and sbr_wdata_o come from manager sel. They are combinational and have zero added latency.
- Grant:
  - mgr_gnt_o[sel] = sbr_gnt_i AND sbr_req_o. All other grant bits are 0.
  - On a grant: push sel into the FIFO, set rr_ptr = (sel+1) mod NumMgr, clear lock.
- Lock:
  - If sbr_req_o = 1 and sbr_gnt_i = 0, then lock is set to 1 and locked_idx = sel at the next edge.
  - This keeps the subordinate-side request stable until it is granted.
  - A locked manager that drops its request (a protocol violation) clears lock. sbr_req_o then deasserts that cycle.
- FIFO full:
  - When fifo_full, sbr_req_o = 0 and no manager is granted, even if a response pops the FIFO in the same cycle. Issue resumes the cycle after the pop.
  - Lock state is kept while the FIFO is full.
- Response:
  - On sbr_rvalid_i, mgr_rvalid_o[fifo_head] = 1 in the same cycle (combinational), then the FIFO pops.
  - mgr_rdata_o = sbr_rdata_i and mgr_err_o = sbr_err_i, passed through unmodified.
- Same-cycle grant and response: push and pop both occur and the count is unchanged. The response belongs to the older entry.
- Empty-FIFO response: no mgr_rvalid_o is asserted, resp_orphan_o pulses for one cycle, and FIFO state is unchanged.
- outstanding_o equals the FIFO occupancy (0 to MaxTrans), registered.
- Ordering: responses are returned in grant order, because the subordinate is in-order.
- Asynchronous reset mid-transaction: all state returns to reset values immediately. In-flight responses are dropped, and any that arrive after reset count as orphans.
- The FIFO is a circular buffer of MaxTrans entries, each $clog2(NumMgr) bits wide. Read and write pointers wrap modulo MaxTrans.
- rr_ptr wraps from NumMgr-1 to 0.

Test Plan:
- Single manager: mgr_req_i = 3'b010, sbr_gnt_i = 1 every cycle, rvalid one cycle after each grant → mgr_gnt_o = 3'b010 each cycle, mgr_rvalid_o = 3'b010 one cycle later, outstanding_o toggles between 0 and 1.
- Round-robin fairness: all three managers requesting continuously with an always-granting subordinate → grant sequence 0,1,2,0,1,2, i.e. exactly 2 grants each over 6 cycles.
- Lock: managers 0 and 2 request, sbr_gnt_i held at 0 for 4 cycles, manager 0 selected → sbr_addr_o stays manager 0's address for all 4 cycles. When the grant arrives it goes to 0, and the next grant goes to 2.
- Backpressure: MaxTrans = 2, grants accepted for managers 0 and 1, no rvalid → sbr_req_o = 0, outstanding_o = 2. Then one rvalid → mgr_rvalid_o = 3'b001, and issue resumes the following cycle.
- Simultaneous push and pop: grant to manager 2 and rvalid for manager 1 in the same cycle → mgr_rvalid_o = 3'b010, outstanding_o unchanged, and the next rvalid goes to manager 2. Also: an rvalid with the FIFO empty → resp_orphan_o pulses once and mgr_rvalid_o = 0.
- Reset mid-operation: assert rst_ni low with 2 transactions outstanding → outstanding_o = 0 and all outputs 0 asynchronously. After release, the first grant goes to manager 0.
